jkff_monitor: RTL and testbench

JKFF_MONITOR -- requirements
Module: jkff_monitor

---
 rtl/jkff_monitor.sv | 110 +++++++++++
 tb/tb_jkff_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/jkff_monitor.sv
// Self-checking monitor for an external JK flip-flop.
// A reference model tracks the expected Q, and the monitor counts comparisons and mismatches.
// Define JKMON_NOTQ_CHECK_EN to also flag cycles where notQ is not the complement of Q.
module jkff_monitor #(
    parameter int ERR_CNT_W = 8,
    parameter int CHK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 stop,
    input  logic                 clr,
    input  logic                 J,
    input  logic                 K,
    input  logic                 Q,
    input  logic                 notQ,
    output logic                 busy,
    output logic                 exp_q,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [CHK_CNT_W-1:0] chk_cnt,
    output logic [CHK_CNT_W-1:0] first_err_cyc
);

    typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);
    localparam logic [CHK_CNT_W-1:0] CHK_ONE = CHK_CNT_W'(1);

    state_t state, state_nxt;
    logic   exp_q_nxt;
    logic   cmp;
    logic   mismatch;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

`ifdef JKMON_NOTQ_CHECK_EN
    // One mismatch per cycle, whether Q is wrong, notQ is inconsistent, or both.
    assign mismatch = (Q != exp_q) || (notQ == Q);
`else
    logic notq_unused;
    assign notq_unused = notQ;
    assign mismatch    = (Q != exp_q);
`endif

    assign busy = (state != IDLE);

    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        exp_q_nxt = exp_q;
        cmp       = 1'b0;
        case (state)
            IDLE: begin
                if (arm) state_nxt = SYNC;
            end
            SYNC: begin
                exp_q_nxt = jk_next(Q, J, K);
                state_nxt = CHECK;
            end
            CHECK: begin
                cmp       = 1'b1;
                exp_q_nxt = jk_next(exp_q, J, K);
                if (stop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            exp_q <= 1'b0;
        end else begin
            state <= state_nxt;
            exp_q <= exp_q_nxt;
        end
    end

    // clr outranks a compare in the same cycle. It leaves the FSM and exp_q untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err           <= 1'b0;
            err_cnt       <= '0;
            chk_cnt       <= '0;
            first_err_cyc <= '0;
        end else if (clr) begin
            err           <= 1'b0;
            err_cnt       <= '0;
            chk_cnt       <= '0;
            first_err_cyc <= '0;
        end else if (cmp) begin
            if (chk_cnt != '1) chk_cnt <= chk_cnt + CHK_ONE;
            if (mismatch) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
                if (!err) first_err_cyc <= chk_cnt;
            end
        end
    end

endmodule

// File: tb/tb_jkff_monitor.sv
// Directed bench for jkff_monitor. A behavioural JK flip-flop drives the monitor.
// A reference model pushes the expected outputs to a scoreboard queue, and each entry is popped after the clock edge.
module tb_jkff_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0, stop = 1'b0, clr = 1'b0;
    logic        J = 1'b0, K = 1'b0, Q = 1'b0, notQ = 1'b1;
    logic        busy, exp_q, err;
    logic [7:0]  err_cnt;
    logic [15:0] chk_cnt, first_err_cyc;

    jkff_monitor #(.ERR_CNT_W(8), .CHK_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop), .clr(clr),
        .J(J), .K(K), .Q(Q), .notQ(notQ),
        .busy(busy), .exp_q(exp_q), .err(err), .err_cnt(err_cnt),
        .chk_cnt(chk_cnt), .first_err_cyc(first_err_cyc)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {M_IDLE, M_SYNC, M_CHECK} mstate_t;
    typedef struct packed {
        logic        busy;
        logic        expq;
        logic        err;
        logic [7:0]  ecnt;
        logic [15:0] ccnt;
        logic [15:0] first;
    } exp_t;

    exp_t    sb[$];
    mstate_t m_state = M_IDLE;
    logic    m_exp = 1'b0, m_err = 1'b0;
    logic [7:0]  m_ecnt = '0;
    logic [15:0] m_ccnt = '0, m_first = '0;
    logic    ff_q = 1'b0;
    int      checks = 0, passes = 0;

    function automatic logic jk(input logic q, input logic j, input logic k);
        if (!j && !k) return q;
        if (!j && k)  return 1'b0;
        if (j && !k)  return 1'b1;
        return ~q;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_exp = 1'b0; m_err = 1'b0;
        m_ecnt = '0; m_ccnt = '0; m_first = '0;
        sb.delete();
    endtask

    // One clock cycle. Inputs are driven at posedge+1, and the outputs are popped and compared at the next posedge+1.
    task automatic step(input string tag, input logic a, input logic s, input logic c,
                        input logic j, input logic k, input logic bad_q, input logic nq_eq);
        logic mis;
        exp_t e, g;
        arm = a; stop = s; clr = c; J = j; K = k;
        Q    = bad_q ? ~ff_q : ff_q;
        notQ = nq_eq ? Q : ~Q;
        mis  = (Q != m_exp);
`ifdef JKMON_NOTQ_CHECK_EN
        mis  = mis || (notQ == Q);
`endif
        case (m_state)
            M_IDLE: if (a) m_state = M_SYNC;
            M_SYNC: begin m_exp = jk(Q, j, k); m_state = M_CHECK; end
            default: begin
                if (!c) begin
                    if (mis) begin
                        if (!m_err) m_first = m_ccnt;
                        m_err = 1'b1;
                        if (m_ecnt != 8'hff) m_ecnt++;
                    end
                    if (m_ccnt != 16'hffff) m_ccnt++;
                end
                m_exp = jk(m_exp, j, k);
                if (s) m_state = M_IDLE;
            end
        endcase
        if (c) begin m_err = 1'b0; m_ecnt = '0; m_ccnt = '0; m_first = '0; end
        e = '{busy: (m_state != M_IDLE), expq: m_exp, err: m_err, ecnt: m_ecnt,
              ccnt: m_ccnt, first: m_first};
        sb.push_back(e);
        @(posedge clk); #1;
        ff_q = jk(ff_q, j, k);
        g = sb.pop_front();
        check({tag, ".busy"},  {15'd0, busy},   {15'd0, g.busy});
        check({tag, ".exp_q"}, {15'd0, exp_q},  {15'd0, g.expq});
        check({tag, ".err"},   {15'd0, err},    {15'd0, g.err});
        check({tag, ".err_cnt"}, {8'd0, err_cnt}, {8'd0, g.ecnt});
        check({tag, ".chk_cnt"}, chk_cnt,        g.ccnt);
        check({tag, ".first"},   first_err_cyc,  g.first);
        arm = 1'b0; stop = 1'b0; clr = 1'b0;
    endtask

    logic [1:0] jk_pat [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b11};

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset.busy", {15'd0, busy}, 16'd0);
        check("reset.chk_cnt", chk_cnt, 16'd0);

        // Correct flip-flop, 10 compares, stop on the last compare.
        step("t1.arm", 1, 0, 0, 0, 0, 0, 0);
        step("t1.sync", 0, 0, 0, jk_pat[0][1], jk_pat[0][0], 0, 0);
        for (int i = 0; i < 10; i++)
            step("t1.chk", 0, (i == 9), 0, jk_pat[(i+1)%5][1], jk_pat[(i+1)%5][0], 0, 0);
        check("t1.final_err", {15'd0, err}, 16'd0);
        check("t1.final_err_cnt", {8'd0, err_cnt}, 16'd0);
        check("t1.final_chk_cnt", chk_cnt, 16'd10);
        check("t1.final_busy", {15'd0, busy}, 16'd0);
        step("t1.idle_stop", 0, 1, 0, 1, 0, 0, 0);

        // Two forced mismatches, on the 3rd and 5th compares.
        step("t2.clr", 0, 0, 1, 0, 0, 0, 0);
        step("t2.arm", 1, 0, 0, 0, 0, 0, 0);
        step("t2.sync", 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step("t2.chk", (i == 2), (i == 5), 0, i[0], 1, (i == 2 || i == 4), 0);
        check("t2.err", {15'd0, err}, 16'd1);
        check("t2.err_cnt", {8'd0, err_cnt}, 16'd2);
        check("t2.first", first_err_cyc, 16'd2);

        // err_cnt saturates at 255.
        step("t3.clr", 0, 0, 1, 0, 0, 0, 0);
        step("t3.arm", 1, 0, 0, 0, 0, 0, 0);
        step("t3.sync", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            step("t3.chk", 0, 0, 0, i[1], i[0], 1, 0);
        check("t3.err_cnt_sat", {8'd0, err_cnt}, 16'd255);
        step("t3.hold", 0, 1, 0, 1, 1, 1, 0);
        check("t3.err_cnt_hold", {8'd0, err_cnt}, 16'd255);

        // clr in the same cycle as a mismatch discards that compare.
        step("t4.clr", 0, 0, 1, 0, 0, 0, 0);
        step("t4.arm", 1, 0, 0, 0, 0, 0, 0);
        step("t4.sync", 0, 0, 0, 1, 1, 0, 0);
        step("t4.clr_mis", 0, 0, 1, 0, 0, 1, 0);
        check("t4.err_after_clr", {15'd0, err}, 16'd0);
        check("t4.err_cnt_after_clr", {8'd0, err_cnt}, 16'd0);
        step("t4.mis", 0, 0, 0, 0, 1, 1, 0);
        check("t4.err_cnt_next", {8'd0, err_cnt}, 16'd1);
        check("t4.first_next", first_err_cyc, 16'd0);
        step("t4.ok", 0, 0, 0, 1, 0, 0, 0);

        // Asynchronous reset mid-CHECK while err=1.
        #2 rst_n = 1'b0;
        #1;
        check("t5.busy", {15'd0, busy}, 16'd0);
        check("t5.exp_q", {15'd0, exp_q}, 16'd0);
        check("t5.err", {15'd0, err}, 16'd0);
        check("t5.err_cnt", {8'd0, err_cnt}, 16'd0);
        check("t5.chk_cnt", chk_cnt, 16'd0);
        check("t5.first", first_err_cyc, 16'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            step("t5.no_arm", 0, 0, 0, 1, 1, 1, 0);
        check("t5.still_idle", {15'd0, busy}, 16'd0);
        step("t5.arm", 1, 0, 0, 0, 0, 0, 0);
        check("t5.rearmed", {15'd0, busy}, 16'd1);
        step("t5.sync", 0, 0, 0, 0, 0, 0, 0);
        step("t5.chk", 0, 1, 0, 0, 0, 0, 0);

        // Correct Q with notQ equal to Q for a single compare.
        step("t6.clr", 0, 0, 1, 0, 0, 0, 0);
        step("t6.arm", 1, 0, 0, 0, 0, 0, 0);
        step("t6.sync", 0, 0, 0, 1, 0, 0, 0);
        step("t6.chk", 0, 1, 0, 0, 0, 0, 1);
`ifdef JKMON_NOTQ_CHECK_EN
        check("t6.notq_err_cnt", {8'd0, err_cnt}, 16'd1);
`else
        check("t6.notq_err_cnt", {8'd0, err_cnt}, 16'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
